gauss3x3_stream: RTL

//  Streaming 3x3 Gaussian smoother directly upstream of canny_simple: accepts one gray pixel per gray_valid strobe,

---
 rtl/gauss_pkg.sv | 36 +++
 rtl/gauss3x3_stream_line_buffer.sv | 23 ++
 rtl/gauss3x3_stream.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/gauss_pkg.sv
// Shared constants, types and kernel arithmetic for the 3x3 Gaussian smoother.
package gauss_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned TAG_W     = 32;
    localparam int unsigned SUM_W     = 12;
    localparam int unsigned ROUND     = 8;
    localparam int unsigned SHIFT     = 4;
    localparam int unsigned K_CORNER  = 1;
    localparam int unsigned K_EDGE    = 2;
    localparam int unsigned K_CENTRE  = 4;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } gauss_state_e;

    typedef struct packed {
        logic [TAG_W-1:0] row;
        logic [TAG_W-1:0] col;
    } pix_tag_t;

    // [row][col], row 0 = top, col 0 = left
    typedef logic [2:0][2:0][PIX_W-1:0] window_t;

    function automatic logic [SUM_W-1:0] gauss_sum(input window_t t);
        logic [SUM_W-1:0] corners;
        logic [SUM_W-1:0] edges;
        corners = SUM_W'(t[0][0]) + SUM_W'(t[0][2]) + SUM_W'(t[2][0]) + SUM_W'(t[2][2]);
        edges   = SUM_W'(t[0][1]) + SUM_W'(t[1][0]) + SUM_W'(t[1][2]) + SUM_W'(t[2][1]);
        return corners * SUM_W'(K_CORNER) + edges * SUM_W'(K_EDGE)
             + SUM_W'(t[1][1]) * SUM_W'(K_CENTRE);
    endfunction

endpackage

// File: rtl/gauss3x3_stream_line_buffer.sv
// One-row delay line: combinational read and write share an address, so a read sees the old row.
module gauss_line_buffer #(
    parameter int unsigned DEPTH = 320,
    parameter int unsigned DW    = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DW-1:0]            wr_data,
    output logic [DW-1:0]            rd_data
);

    logic [DW-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/gauss3x3_stream.sv
// Streaming 3x3 Gaussian smoother with row/col tags and end-of-frame flush.
// Define GAUSS_BORDER_REPLICATE_EN to clamp border taps; otherwise border centres pass through unfiltered.
module gauss3x3_stream
    import gauss_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = 320,
    parameter int unsigned IMAGE_HEIGHT = 240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gray_valid,
    input  logic [PIX_W-1:0] gray,
    output logic             blur_valid,
    output logic [PIX_W-1:0] blur_out,
    output logic [TAG_W-1:0] center_row,
    output logic [TAG_W-1:0] center_col,
    output logic             busy
);

    localparam int unsigned AW = $clog2(IMAGE_WIDTH);
    localparam logic [TAG_W-1:0] COL_LAST = TAG_W'(IMAGE_WIDTH - 1);
    localparam logic [TAG_W-1:0] ROW_LAST = TAG_W'(IMAGE_HEIGHT - 1);
    localparam logic [TAG_W-1:0] FL_LAST  = TAG_W'(IMAGE_WIDTH);
    localparam logic [TAG_W-1:0] ONE      = TAG_W'(1);

    gauss_state_e state_q, state_d;
    logic [TAG_W-1:0] in_row, in_col, fl_cnt;
    pix_tag_t out_tag;
    logic accept, flush_step, produce, trig;

    logic [AW-1:0]    lb_addr;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic [2:0][PIX_W-1:0] col_new;

    window_t  win;
    pix_tag_t w_tag;
    logic     w_valid;
    logic     top_bad, bot_bad, left_bad, right_bad;
    logic [SUM_W-1:0] sum_c;

    logic [SUM_W-1:0] s1_sum;
    pix_tag_t s1_tag;
    logic     s1_valid;

    // Next-state and trigger decode; flush steps stand in for the missing row below the image
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        flush_step = 1'b0;
        produce    = 1'b0;
        case (state_q)
            FILL: begin
                accept = gray_valid;
                if (gray_valid && in_row == ONE && in_col == '0) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                accept  = gray_valid;
                produce = gray_valid;
                if (gray_valid && in_row == ROW_LAST && in_col == COL_LAST) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                flush_step = 1'b1;
                produce    = 1'b1;
                if (fl_cnt == FL_LAST) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign trig = accept | flush_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            busy    <= 1'b0;
            in_row  <= '0;
            in_col  <= '0;
            fl_cnt  <= '0;
            out_tag <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == FLUSH);
            if (accept) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + ONE;
                end else begin
                    in_col <= in_col + ONE;
                end
            end
            if (flush_step && fl_cnt != FL_LAST) begin
                fl_cnt <= fl_cnt + ONE;
            end else begin
                fl_cnt <= '0;
            end
            if (produce) begin
                if (out_tag.col == COL_LAST) begin
                    out_tag.col <= '0;
                    out_tag.row <= (out_tag.row == ROW_LAST) ? '0 : out_tag.row + ONE;
                end else begin
                    out_tag.col <= out_tag.col + ONE;
                end
            end
        end
    end

    // Last flush step reads address 0; that column never reaches a used tap
    assign lb_addr = flush_step ? ((fl_cnt == FL_LAST) ? '0 : AW'(fl_cnt)) : AW'(in_col);

    gauss_line_buffer #(.DEPTH(IMAGE_WIDTH), .DW(PIX_W)) u_lb0 (
        .clk     (clk),
        .we      (accept),
        .addr    (lb_addr),
        .wr_data (gray),
        .rd_data (lb0_rd)
    );

    gauss_line_buffer #(.DEPTH(IMAGE_WIDTH), .DW(PIX_W)) u_lb1 (
        .clk     (clk),
        .we      (accept),
        .addr    (lb_addr),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    assign col_new[0] = lb1_rd;
    assign col_new[1] = lb0_rd;
    assign col_new[2] = flush_step ? '0 : gray;

    // Window: newest column enters on the right; centre is always win[1][1]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win     <= '0;
            w_tag   <= '0;
            w_valid <= 1'b0;
        end else begin
            w_valid <= produce;
            if (trig) begin
                win[0] <= {col_new[0], win[0][2], win[0][1]};
                win[1] <= {col_new[1], win[1][2], win[1][1]};
                win[2] <= {col_new[2], win[2][2], win[2][1]};
                w_tag  <= out_tag;
            end
        end
    end

    assign top_bad   = (w_tag.row == '0);
    assign bot_bad   = (w_tag.row == ROW_LAST);
    assign left_bad  = (w_tag.col == '0);
    assign right_bad = (w_tag.col == COL_LAST);

`ifdef GAUSS_BORDER_REPLICATE_EN
    window_t rw, cw;

    // Clamp rows first, then columns, so corner taps collapse onto the centre
    always_comb begin
        rw = win;
        if (top_bad) rw[0] = win[1];
        if (bot_bad) rw[2] = win[1];
        cw = rw;
        if (left_bad) begin
            cw[0][0] = rw[0][1];
            cw[1][0] = rw[1][1];
            cw[2][0] = rw[2][1];
        end
        if (right_bad) begin
            cw[0][2] = rw[0][1];
            cw[1][2] = rw[1][1];
            cw[2][2] = rw[2][1];
        end
        sum_c = gauss_sum(cw);
    end
`else
    // Centre scaled by 16 rounds back to itself in stage 2
    always_comb begin
        if (top_bad || bot_bad || left_bad || right_bad) begin
            sum_c = SUM_W'(win[1][1]) << SHIFT;
        end else begin
            sum_c = gauss_sum(win);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sum     <= '0;
            s1_tag     <= '0;
            s1_valid   <= 1'b0;
            blur_valid <= 1'b0;
            blur_out   <= '0;
            center_row <= '0;
            center_col <= '0;
        end else begin
            s1_sum     <= sum_c;
            s1_tag     <= w_tag;
            s1_valid   <= w_valid;
            blur_valid <= s1_valid;
            if (s1_valid) begin
                blur_out   <= PIX_W'((s1_sum + SUM_W'(ROUND)) >> SHIFT);
                center_row <= s1_tag.row;
                center_col <= s1_tag.col;
            end
        end
    end

endmodule
